// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68000-style bus initiator.
package m68k_bus_pkg;

  localparam int ADDR_W_DEF = 20;

  // Fixed E-clock emulation delay applied after a VPA termination.
  localparam int VPA_DELAY = 10;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    STRB,
    WAIT,
    REL
  } bus_state_e;

endpackage

// File: rtl/m68k_bus_initiator_if.sv
// Board bus seen from the initiator (master) and from the glue/responder (slave).
interface m68k_bus_initiator_if #(
  parameter int ADDR_W = 20
);
  logic [ADDR_W-1:0] addr;
  logic              rw;
  logic              _as;
  logic              _ds;
  logic [7:0]        da_out;
  logic              da_oe;
  logic [7:0]        da_in;
  logic              _dtack;
  logic              _vpa;

  modport master (
    output addr, rw, _as, _ds, da_out, da_oe,
    input  da_in, _dtack, _vpa
  );

  modport slave (
    input  addr, rw, _as, _ds, da_out, da_oe,
    output da_in, _dtack, _vpa
  );
endinterface

// File: rtl/m68k_bus_initiator_bus_sync.sv
// N-stage synchronizer for active-low bus terminations. Resets to 1 and can
// be flushed to 1 so a stale acknowledge never leaks into the next cycle.
module bus_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic _reset,
  input  logic flush,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  // Shift chain; a flush re-arms it to the negated level.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      ff <= '1;
    end else if (flush) begin
      ff <= '1;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/m68k_bus_initiator.sv
// 68000-style asynchronous bus initiator: takes one command from the local
// valid/ready port, runs one strobed bus cycle, returns a one-cycle response.
// Optional VPA (E-clock emulated) termination: define M68K_BUS_INITIATOR_VPA_EN.
module m68k_bus_initiator
  import m68k_bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  m68k_bus_initiator_if.master bus
);
  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  bus_state_e        state_q, state_d;
  logic              ready_q, rw_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q, rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              dtack_s, vpa_hold, vpa_done;
  logic              term, tmo, as_n, ds_n, oe;
  logic              sync_flush;

  // Terminations only count while waiting; elsewhere the chains sit at 1,
  // which also gives every cycle the full synchronizer latency.
  assign sync_flush = (state_q != WAIT);

  bus_sync #(.STAGES(SYNC_STAGES)) u_dtack_sync (
    .clk(clk), ._reset(_reset), .flush(sync_flush), .d(bus._dtack), .q(dtack_s)
  );

`ifdef M68K_BUS_INITIATOR_VPA_EN
  localparam int VPA_CNT_W = $clog2(VPA_DELAY);
  logic                 vpa_s, vpa_act_q;
  logic [VPA_CNT_W-1:0] vpa_cnt_q;

  bus_sync #(.STAGES(SYNC_STAGES)) u_vpa_sync (
    .clk(clk), ._reset(_reset), .flush(sync_flush), .d(bus._vpa), .q(vpa_s)
  );

  // E-clock delay: armed by synchronized VPA, runs to completion inside WAIT.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      vpa_act_q <= 1'b0;
      vpa_cnt_q <= '0;
    end else if (state_q != WAIT) begin
      vpa_act_q <= 1'b0;
      vpa_cnt_q <= '0;
    end else if (vpa_act_q) begin
      vpa_cnt_q <= vpa_cnt_q + 1'b1;
    end else if (!vpa_s) begin
      vpa_act_q <= 1'b1;
    end
  end

  assign vpa_hold = vpa_act_q | ~vpa_s;
  assign vpa_done = vpa_act_q & (vpa_cnt_q == VPA_CNT_W'(VPA_DELAY - 1));
`else
  assign vpa_hold = 1'b0;
  assign vpa_done = 1'b0;
`endif

  // State register; reset returns to IDLE, which negates strobes at once.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and strobe/handshake decode; DTACK beats VPA and timeout.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    as_n      = 1'b1;
    ds_n      = 1'b1;
    oe        = 1'b0;
    term      = 1'b0;
    tmo       = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = ready_q;
        if (cmd_valid && ready_q) state_d = ADDR;
      end
      ADDR: begin
        oe      = ~rw_q;
        state_d = STRB;
      end
      STRB: begin
        as_n    = 1'b0;
        ds_n    = ~rw_q;
        oe      = ~rw_q;
        state_d = WAIT;
      end
      WAIT: begin
        as_n = 1'b0;
        ds_n = 1'b0;
        oe   = ~rw_q;
        term = ~dtack_s | vpa_done;
        tmo  = ~term & ~vpa_hold & (cnt_q == CNT_LAST);
        if (term || tmo) state_d = REL;
      end
      REL: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command capture, wait counter, read data and error latch.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      ready_q <= 1'b0;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ready_q <= 1'b1;
      if (state_q == IDLE && cmd_valid && ready_q) begin
        rw_q    <= cmd_rw;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      if (state_q != WAIT) cnt_q <= '0;
      else if (!vpa_hold && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      if (term) begin
        err_q <= 1'b0;
        if (rw_q) rdata_q <= bus.da_in;
      end else if (tmo) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.addr   = addr_q;
  assign bus.rw     = rw_q;
  assign bus._as    = as_n;
  assign bus._ds    = ds_n;
  assign bus.da_out = wdata_q;
  assign bus.da_oe  = oe;
  assign rsp_rdata  = rdata_q;
endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Self-checking bench for m68k_bus_initiator with a scripted DTACK responder
// and a response scoreboard.
module tb_m68k_bus_initiator;
  import m68k_bus_pkg::*;

  localparam int ADDR_W      = 20;
  localparam int TIMEOUT     = 255;
  localparam int SYNC_STAGES = 2;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  logic              clk = 1'b0;
  logic              _reset;
  logic              cmd_valid, cmd_ready, cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_wdata;
  logic              rsp_valid, rsp_err;
  logic [7:0]        rsp_rdata;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [7:0] last_rd;
  int   dtack_mode = 0;
  int   dtack_dly = 3;
  int   ds_cnt = 0;
  int   wait_cyc = 0;
  int   rsp_seen = 0;
  int   cyc = 0;

  m68k_bus_initiator_if #(.ADDR_W(ADDR_W)) bus ();

  m68k_bus_initiator #(
    .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), ._reset(_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // DTACK responder: 0 = never, 1 = tied low, 2 = low dtack_dly clocks after _ds falls.
  always @(negedge clk) begin
    case (dtack_mode)
      0: bus._dtack = 1'b1;
      1: bus._dtack = 1'b0;
      default: begin
        if (bus._ds === 1'b0) begin
          ds_cnt = ds_cnt + 1;
          bus._dtack = (ds_cnt >= dtack_dly) ? 1'b0 : 1'b1;
        end else begin
          ds_cnt = 0;
          bus._dtack = 1'b1;
        end
      end
    endcase
  end

  // Bus observer: counts clocks with both strobes low, and response pulses.
  always @(negedge clk) begin
    if (bus._as === 1'b0 && bus._ds === 1'b0) wait_cyc = wait_cyc + 1;
    if (rsp_valid === 1'b1) rsp_seen = rsp_seen + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic r, input logic [ADDR_W-1:0] a,
                          input logic [7:0] d, output bit ok);
    cmd_rw = r; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_rw = ~r; cmd_addr = ~a; cmd_wdata = ~d;
  endtask

  task automatic wait_rsp(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    _reset = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b1; cmd_addr = '0; cmd_wdata = '0;
    bus.da_in = 8'h00; bus._vpa = 1'b1; dtack_mode = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus._as, bus._ds, bus.rw, bus.da_oe} !== 4'b1110) begin
      errors++; $display("FAIL reset_bus got %b exp 1110", {bus._as, bus._ds, bus.rw, bus.da_oe});
    end
    checks++;
    if ({bus.addr, bus.da_out} !== 28'h0) begin
      errors++; $display("FAIL reset_addr_data got %h exp 0", {bus.addr, bus.da_out});
    end
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_rdata} !== 11'h0) begin
      errors++; $display("FAIL reset_local got %h exp 0", {cmd_ready, rsp_valid, rsp_err, rsp_rdata});
    end
    _reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
    last_rd = 8'h00;
  endtask

  task automatic test_read;
    bit ok; exp_t e;
    sb.delete();
    dtack_mode = 2; dtack_dly = 3; bus.da_in = 8'hA5;
    send_cmd(1'b1, 20'h00100, 8'h00, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL read_accept got 0 exp 1"); end
    sb.push_back('{8'hA5, 1'b0});
    @(negedge clk);
    checks++;
    if ({bus.addr, bus.rw, bus._as, bus._ds, bus.da_oe} !== {20'h00100, 4'b1110}) begin
      errors++; $display("FAIL read_addr_phase got %h exp %h",
                         {bus.addr, bus.rw, bus._as, bus._ds, bus.da_oe}, {20'h00100, 4'b1110});
    end
    @(negedge clk);
    checks++;
    if ({bus._as, bus._ds} !== 2'b00) begin
      errors++; $display("FAIL read_strobes got %b exp 00", {bus._as, bus._ds});
    end
    wait_rsp(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL read_rsp_timeout got 0 exp 1"); end
    else begin
      e = sb.pop_front();
      checks++;
      if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
        errors++; $display("FAIL read_rsp got %h/%b exp %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
      checks++;
      if ({bus._as, bus._ds} !== 2'b11) begin
        errors++; $display("FAIL read_rel_strobes got %b exp 11", {bus._as, bus._ds});
      end
      @(negedge clk);
      checks++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
        errors++; $display("FAIL read_after got %b exp 01", {rsp_valid, cmd_ready});
      end
    end
    last_rd = 8'hA5;
  endtask

  task automatic test_write;
    bit ok; exp_t e;
    sb.delete();
    dtack_mode = 2; dtack_dly = 3;
    send_cmd(1'b0, 20'h7E000, 8'h3C, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL write_accept got 0 exp 1"); end
    sb.push_back('{last_rd, 1'b0});
    @(negedge clk);
    checks++;
    if ({bus.addr, bus.da_out, bus.da_oe, bus._as, bus._ds, bus.rw} !== {20'h7E000, 8'h3C, 4'b1110}) begin
      errors++; $display("FAIL write_addr_phase got %h exp %h",
                         {bus.addr, bus.da_out, bus.da_oe, bus._as, bus._ds, bus.rw},
                         {20'h7E000, 8'h3C, 4'b1110});
    end
    @(negedge clk);
    checks++;
    if ({bus._as, bus._ds, bus.da_oe} !== 3'b011) begin
      errors++; $display("FAIL write_strb_phase got %b exp 011", {bus._as, bus._ds, bus.da_oe});
    end
    @(negedge clk);
    checks++;
    if ({bus._as, bus._ds, bus.da_oe, bus.da_out, bus.addr} !== {3'b001, 8'h3C, 20'h7E000}) begin
      errors++; $display("FAIL write_ds_phase got %h exp %h",
                         {bus._as, bus._ds, bus.da_oe, bus.da_out, bus.addr}, {3'b001, 8'h3C, 20'h7E000});
    end
    wait_rsp(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL write_rsp_timeout got 0 exp 1"); end
    else begin
      e = sb.pop_front();
      checks++;
      if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
        errors++; $display("FAIL write_rsp got %h/%b exp %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
      checks++;
      if ({bus._as, bus._ds, bus.da_oe} !== 3'b110) begin
        errors++; $display("FAIL write_rel got %b exp 110", {bus._as, bus._ds, bus.da_oe});
      end
    end
  endtask

  task automatic test_timeout;
    bit ok; exp_t e;
    sb.delete();
    dtack_mode = 0; wait_cyc = 0;
    send_cmd(1'b0, 20'h00200, 8'h11, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tmo_accept got 0 exp 1"); end
    sb.push_back('{last_rd, 1'b1});
    wait_rsp(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tmo_rsp_timeout got 0 exp 1"); end
    else begin
      e = sb.pop_front();
      checks++;
      if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
        errors++; $display("FAIL tmo_rsp got %h/%b exp %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
      checks++;
      if (wait_cyc != TIMEOUT) begin
        errors++; $display("FAIL tmo_wait_cycles got %0d exp %0d", wait_cyc, TIMEOUT);
      end
      checks++;
      if ({bus._as, bus._ds, bus.da_oe} !== 3'b110) begin
        errors++; $display("FAIL tmo_rel got %b exp 110", {bus._as, bus._ds, bus.da_oe});
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok; exp_t e; int prev;
    sb.delete();
    dtack_mode = 1; prev = 0;
    cmd_rw = 1'b1; cmd_addr = 20'h00300; cmd_wdata = 8'h00; cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_accept_%0d got 0 exp 1", k); end
      checks++;
      if ({bus._as, bus._ds} !== 2'b11) begin
        errors++; $display("FAIL b2b_idle_strobes_%0d got %b exp 11", k, {bus._as, bus._ds});
      end
      if (k > 0) begin
        checks++;
        if (cyc - prev != 5 + SYNC_STAGES) begin
          errors++; $display("FAIL b2b_cycle_len_%0d got %0d exp %0d", k, cyc - prev, 5 + SYNC_STAGES);
        end
      end
      prev = cyc;
      bus.da_in = 8'(8'h10 + k);
      sb.push_back('{8'(8'h10 + k), 1'b0});
      if (k == 3) begin
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
      end
      wait_rsp(50, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_rsp_timeout_%0d got 0 exp 1", k); end
      else begin
        e = sb.pop_front();
        checks++;
        if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
          errors++; $display("FAIL b2b_rsp_%0d got %h/%b exp %h/%b", k, rsp_rdata, rsp_err, e.rdata, e.err);
        end
      end
    end
    last_rd = 8'h13;
  endtask

  task automatic test_vpa;
    bit ok; exp_t e; int exp_wait;
    sb.delete();
    dtack_mode = 0; bus._vpa = 1'b0; bus.da_in = 8'hC3; wait_cyc = 0;
    send_cmd(1'b1, 20'h00400, 8'h00, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL vpa_accept got 0 exp 1"); end
`ifdef M68K_BUS_INITIATOR_VPA_EN
    sb.push_back('{8'hC3, 1'b0});
    exp_wait = 1 + SYNC_STAGES + 1 + VPA_DELAY;
`else
    sb.push_back('{last_rd, 1'b1});
    exp_wait = 1 + TIMEOUT;
`endif
    wait_rsp(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL vpa_rsp_timeout got 0 exp 1"); end
    else begin
      e = sb.pop_front();
      checks++;
      if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
        errors++; $display("FAIL vpa_rsp got %h/%b exp %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
      checks++;
      if (wait_cyc != exp_wait) begin
        errors++; $display("FAIL vpa_strobe_cycles got %0d exp %0d", wait_cyc, exp_wait);
      end
    end
    bus._vpa = 1'b1;
`ifdef M68K_BUS_INITIATOR_VPA_EN
    last_rd = 8'hC3;
`endif
  endtask

  task automatic test_reset_abort;
    bit ok; exp_t e; int snap;
    sb.delete();
    dtack_mode = 0;
    send_cmd(1'b0, 20'h12345, 8'h77, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_accept got 0 exp 1"); end
    repeat (3) @(negedge clk);
    checks++;
    if ({bus._as, bus._ds, bus.da_oe} !== 3'b001) begin
      errors++; $display("FAIL abort_pre_wait got %b exp 001", {bus._as, bus._ds, bus.da_oe});
    end
    #2;
    _reset = 1'b0;
    #1;
    checks++;
    if ({bus._as, bus._ds, bus.da_oe, cmd_ready} !== 4'b1100) begin
      errors++; $display("FAIL abort_async got %b exp 1100", {bus._as, bus._ds, bus.da_oe, cmd_ready});
    end
    snap = rsp_seen;
    repeat (2) @(negedge clk);
    _reset = 1'b1;
    last_rd = 8'h00;
    repeat (20) @(negedge clk);
    checks++;
    if (rsp_seen != snap) begin
      errors++; $display("FAIL abort_no_rsp got %0d exp %0d", rsp_seen, snap);
    end
    dtack_mode = 1; bus.da_in = 8'h5A;
    send_cmd(1'b1, 20'h00500, 8'h00, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_next_accept got 0 exp 1"); end
    sb.push_back('{8'h5A, 1'b0});
    wait_rsp(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_next_rsp_timeout got 0 exp 1"); end
    else begin
      e = sb.pop_front();
      checks++;
      if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
        errors++; $display("FAIL abort_next_rsp got %h/%b exp %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    last_rd = 8'h5A;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_back_to_back();
    test_vpa();
    test_reset_abort();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/m68k_bus_initiator.md
Name: m68k_bus_initiator

Overview:
- 68000-style asynchronous bus initiator (master) for the 20-bit/8-bit board bus.
- The existing glue logic decodes _as/_ds/rw/addr and answers with _dtack/_vpa. This block is the other end: it generates the strobes and waits for the termination.
- Used as the board's bus-exerciser/loader to drive ROM/RAM/serial/LED cycles without the CPU. Local side is a valid/ready command port plus a one-cycle response pulse.

Parameters:
- ADDR_W, 20, bus address width (addr[ADDR_W-1:0]).
- TIMEOUT, 255, maximum wait-for-termination cycles before a bus error is reported (1..65535).
- SYNC_STAGES, 2, flip-flop stages on _dtack (and _vpa) before sampling (>=1).

Ports:
- clk  input  1  system clock.
- _reset  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block idle and accepting a command.
- cmd_rw  input  1  1 = read, 0 = write.
- cmd_addr  input  ADDR_W  target address.
- cmd_wdata  input  8  write data.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  8  read data, valid with rsp_valid.
- rsp_err  output  1  timeout flag, valid with rsp_valid.
- addr  output  ADDR_W  bus address.
- rw  output  1  bus direction (1 = read).
- _as  output  1  address strobe, active low.
- _ds  output  1  data strobe, active low.
- da_out  output  8  write data to the pad.
- da_oe  output  1  pad output enable (tristate control at top level).
- da_in  input  8  data from the pad.
- _dtack  input  1  data transfer acknowledge, active low.
- _vpa  input  1  valid peripheral address, active low (used only with the macro).

Behaviour:
- Reset (async, _reset low), all outputs:
  - state IDLE; _as=1, _ds=1, rw=1, da_oe=0, addr=0, da_out=0.
  - cmd_ready=0 while in reset, 1 after.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0; sync chains set to 1.
- Reset mid-cycle aborts immediately: strobes negate and da_oe drops asynchronously, and no response is issued.
- States: IDLE -> ADDR -> STRB -> WAIT -> REL -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready: capture rw, addr and wdata into registers, go to ADDR.
  - cmd_ready is 0 in every other state.
- ADDR (1 cycle):
  - addr and rw driven from the captured registers; strobes stay high.
  - Write: da_oe=1 and da_out=wdata from this cycle through REL.
- STRB (1 cycle):
  - _as=0.
  - Read: _ds=0 in the same cycle.
  - Write: _ds stays 1 here, so data is set up one cycle before the data strobe.
- WAIT:
  - _as=0 and _ds=0.
  - Wait counter starts at 0 and increments every WAIT cycle.
  - Termination when synchronized _dtack = 0.
    - Read: da_in is latched into rsp_rdata on that edge.
    - Go to REL with err=0.
  - If the counter reaches TIMEOUT with no termination: go to REL with err=1; rsp_rdata holds its previous value.
  - If termination and timeout coincide, termination wins (err=0).
- REL (1 cycle):
  - _as=1, _ds=1, da_oe=0; addr and rw are held.
  - rsp_valid=1 with rsp_err for exactly this cycle, then IDLE.
- No wait for _dtack negation: the glue ties _dtack low outside interrupt acknowledge, so waiting would hang.
- Bus timing:
  - Minimum cycle is 5 clocks (ADDR, STRB, 1 WAIT, REL, IDLE) plus SYNC_STAGES latency.
  - Back-to-back commands have at least one IDLE cycle with both strobes high.
- cmd_* inputs are ignored outside IDLE; captured values are stable for the whole cycle.
- Wait counter is ceil(log2(TIMEOUT+1)) bits wide, saturating, and cleared in IDLE.

Optional Feature:
- Macro: M68K_BUS_INITIATOR_VPA_EN.
- Defined:
  - Synchronized _vpa=0 in WAIT also terminates the cycle, after a further 10-clock fixed delay (E-clock emulation) counted inside WAIT.
  - The timeout counter is frozen during that delay.
  - If _dtack and _vpa are both low on the same cycle, _dtack wins.
  - Reads latch da_in at the end of the delay.
- Undefined: _vpa is unconnected internally and has no effect; the port remains present.

Decomposition:
- Shared package m68k_bus_pkg:
  - State enum: IDLE, ADDR, STRB, WAIT, REL.
  - Localparam VPA_DELAY=10.
  - Address width default 20.
- One sub-module: bus_sync, an N-stage synchronizer with reset-to-1. It is instantiated for _dtack and for _vpa.

Test Plan:
- Read, _dtack low 3 clocks after _ds falls, da_in=8'hA5 -> one rsp_valid pulse, rsp_rdata=8'hA5, rsp_err=0; _as/_ds high in REL; cmd_ready returns 1.
- Write addr=20'h7E000 wdata=8'h3C -> da_oe=1 from ADDR; _ds falls one cycle after _as; da_out=8'h3C while _ds=0; rsp_err=0.
- _dtack held high, TIMEOUT=255 -> exactly 255 WAIT cycles, then rsp_valid=1 with rsp_err=1 and strobes negated.
- _dtack tied low permanently, 4 back-to-back reads -> 4 responses, each cycle exactly 5+SYNC_STAGES clocks, >=1 IDLE cycle with both strobes high between cycles.
- _reset pulsed low during WAIT of a write -> _as=_ds=1 and da_oe=0 immediately; no rsp_valid; next command completes normally.
- With macro defined: _vpa low, _dtack high -> termination 10 clocks after synchronized _vpa, rsp_err=0. Without the macro, the same stimulus -> timeout with rsp_err=1.
